// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the per-scanline sprite scanner.
//   - bit positions of the fields in the two sprite attribute words
//   - scan FSM state encoding
//   - number of sprite slots held in the attribute RAM
//   - height_px(): sprite height in pixels from the 2-bit height code
// No ports (package).
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam int NUM_SPRITE_SLOTS = 128;

    // attr0 (RAM word 2n)
    localparam int ADDR_LSB  = 0;
    localparam int ADDR_MSB  = 11;
    localparam int MODE_BIT  = 15;
    localparam int X_LSB     = 16;
    localparam int X_MSB     = 25;

    // attr1 (RAM word 2n+1)
    localparam int Y_LSB     = 0;
    localparam int Y_MSB     = 9;
    localparam int HFLIP_BIT = 16;
    localparam int VFLIP_BIT = 17;
    localparam int Z_LSB     = 18;
    localparam int Z_MSB     = 19;
    localparam int COLL_LSB  = 20;
    localparam int COLL_MSB  = 23;
    localparam int PAL_LSB   = 24;
    localparam int PAL_MSB   = 27;
    localparam int W_LSB     = 28;
    localparam int W_MSB     = 29;
    localparam int H_LSB     = 30;
    localparam int H_MSB     = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_EVAL,
        ST_PUSH,
        ST_FIN
    } scan_state_e;

    // 8, 16, 32 or 64 pixels
    function automatic logic [6:0] height_px(input logic [1:0] h);
        return 7'd8 << h;
    endfunction

endpackage

// File: rtl/sprite_vis_calc.sv
// -----------------------------------------------------------------------------
// sprite_vis_calc
// Combinational vertical-intersection test of one sprite against a scanline.
// Ports:
//   line     in  10  current scanline
//   attr1    in  32  sprite attribute word 1 (Y, VFLIP, Z, H fields used)
//   visible  out  1  sprite enabled (Z != 0) and covers the line
//   row      out  6  row within the sprite, vertical flip applied
// -----------------------------------------------------------------------------
module sprite_vis_calc
    import sprite_pkg::*;
(
    input  logic [9:0]  line,
    input  logic [31:0] attr1,
    output logic        visible,
    output logic [5:0]  row
);

    logic [6:0] height;
    logic [9:0] rel;
    logic       unused_attr;

    // rel wraps modulo 1024, so sprites starting near the bottom of the
    // line space continue at the top.
    always_comb begin
        height  = height_px(attr1[H_MSB:H_LSB]);
        rel     = line - attr1[Y_MSB:Y_LSB];
        visible = (attr1[Z_MSB:Z_LSB] != 2'b00) && (rel < {3'b000, height});
        // 6-bit arithmetic is enough: the flipped row is only kept mod 64
        row     = attr1[VFLIP_BIT] ? (height[5:0] - 6'd1 - rel[5:0]) : rel[5:0];
    end

    assign unused_attr = ^{attr1[29:20], attr1[16:10]};

endmodule

// File: rtl/sprite_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_scan_ctrl
// Per-scanline sprite attribute scanner. On each line start it walks the
// sprite attribute RAM (sprite n at words 2n / 2n+1), tests each sprite for
// vertical intersection with the line and pushes the visible ones, in index
// order, to the line renderer over a valid/ready interface.
//
// Optional build macro: SPRITE_SCAN_OVF_EN
//   adds ovf_o, set when a visible sprite is found after MAX_PER_LINE have
//   been emitted; the scan then keeps evaluating instead of stopping.
//
// Ports:
//   clk_i          in   1  system clock (also the RAM read clock)
//   rst_i          in   1  synchronous active-high reset
//   line_start_i   in   1  scan start pulse; aborts a scan in progress
//   line_i         in  10  line number, sampled with line_start_i
//   ram_rd_en_o    out  1  RAM read enable
//   ram_rd_addr_o  out  8  RAM read address
//   ram_rd_data_i  in  32  RAM read data, one cycle after the address
//   spr_valid_o    out  1  descriptor valid
//   spr_ready_i    in   1  renderer accepts descriptor
//   spr_idx_o      out  7  sprite index
//   spr_addr_o     out 12  pixel data address
//   spr_mode_o     out  1  1 = 8bpp
//   spr_x_o        out 10  x position
//   spr_row_o      out  6  row within sprite, vflip applied
//   spr_hflip_o    out  1  horizontal flip
//   spr_z_o        out  2  priority
//   spr_coll_o     out  4  collision class
//   spr_pal_o      out  4  palette
//   spr_width_o    out  2  width code
//   busy_o         out  1  scan in progress
//   done_o         out  1  one-cycle pulse at scan completion
//   ovf_o          out  1  (SPRITE_SCAN_OVF_EN only) per-line overflow
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for line_start_i
// RD0     | reading attr0 of sprite n
// RD1     | reading attr1 of sprite n, capturing attr0
// EVAL    | capturing attr1, deciding visibility
// PUSH    | waiting for the output register to free up, then loading it
// FIN     | done_o pulse, back to IDLE next cycle
// -----------------------------------------------------------------------------
module sprite_scan_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES  = NUM_SPRITE_SLOTS,
    parameter int MAX_PER_LINE = 64
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        line_start_i,
    input  logic [9:0]  line_i,
    output logic        ram_rd_en_o,
    output logic [7:0]  ram_rd_addr_o,
    input  logic [31:0] ram_rd_data_i,
    output logic        spr_valid_o,
    input  logic        spr_ready_i,
    output logic [6:0]  spr_idx_o,
    output logic [11:0] spr_addr_o,
    output logic        spr_mode_o,
    output logic [9:0]  spr_x_o,
    output logic [5:0]  spr_row_o,
    output logic        spr_hflip_o,
    output logic [1:0]  spr_z_o,
    output logic [3:0]  spr_coll_o,
    output logic [3:0]  spr_pal_o,
    output logic [1:0]  spr_width_o,
`ifdef SPRITE_SCAN_OVF_EN
    output logic        ovf_o,
`endif
    output logic        busy_o,
    output logic        done_o
);

    scan_state_e state;
    logic [9:0]  line_q;
    logic [6:0]  spr_n;
    logic [7:0]  emit_cnt;

    // descriptor fields gathered while reading, held until PUSH can load them
    logic [11:0] p_addr;
    logic        p_mode;
    logic [9:0]  p_x;
    logic [5:0]  p_row;
    logic        p_hflip;
    logic [1:0]  p_z;
    logic [3:0]  p_coll;
    logic [3:0]  p_pal;
    logic [1:0]  p_width;

    logic        vis;
    logic [5:0]  vis_row;
    logic        last_n;
    logic        can_load;
    logic        take;
    logic        stop_at_limit;
    logic        unused_data;

    // In EVAL the RAM is presenting attr1 of the current sprite.
    sprite_vis_calc u_vis_calc (
        .line    (line_q),
        .attr1   (ram_rd_data_i),
        .visible (vis),
        .row     (vis_row)
    );

    assign last_n   = (spr_n == 7'(NUM_SPRITES - 1));
    assign can_load = !spr_valid_o || spr_ready_i;

`ifdef SPRITE_SCAN_OVF_EN
    logic emit_full;
    // past the limit, visible sprites only flag overflow
    assign emit_full     = (emit_cnt == 8'(MAX_PER_LINE));
    assign take          = vis && !emit_full;
    assign stop_at_limit = 1'b0;
`else
    assign take          = vis;
    assign stop_at_limit = ((emit_cnt + 8'd1) == 8'(MAX_PER_LINE));
`endif

    assign unused_data = ^{ram_rd_data_i[31:26], ram_rd_data_i[15:10]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            line_q        <= '0;
            spr_n         <= '0;
            emit_cnt      <= '0;
            p_addr        <= '0;
            p_mode        <= 1'b0;
            p_x           <= '0;
            p_row         <= '0;
            p_hflip       <= 1'b0;
            p_z           <= '0;
            p_coll        <= '0;
            p_pal         <= '0;
            p_width       <= '0;
            ram_rd_en_o   <= 1'b0;
            ram_rd_addr_o <= '0;
            spr_valid_o   <= 1'b0;
            spr_idx_o     <= '0;
            spr_addr_o    <= '0;
            spr_mode_o    <= 1'b0;
            spr_x_o       <= '0;
            spr_row_o     <= '0;
            spr_hflip_o   <= 1'b0;
            spr_z_o       <= '0;
            spr_coll_o    <= '0;
            spr_pal_o     <= '0;
            spr_width_o   <= '0;
`ifdef SPRITE_SCAN_OVF_EN
            ovf_o         <= 1'b0;
`endif
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;

            // a transfer empties the output register unless PUSH reloads it
            if (spr_valid_o && spr_ready_i) begin
                spr_valid_o <= 1'b0;
            end

            if (line_start_i) begin
                // start, or abort-and-restart when already busy
                line_q        <= line_i;
                spr_n         <= '0;
                emit_cnt      <= '0;
                ram_rd_en_o   <= 1'b1;
                ram_rd_addr_o <= '0;
                busy_o        <= 1'b1;
                state         <= ST_RD0;
`ifdef SPRITE_SCAN_OVF_EN
                ovf_o         <= 1'b0;
`endif
                if (state != ST_IDLE) begin
                    spr_valid_o <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy_o <= 1'b0;
                    end

                    ST_RD0: begin
                        ram_rd_addr_o <= {spr_n, 1'b1};
                        state         <= ST_RD1;
                    end

                    ST_RD1: begin
                        ram_rd_en_o <= 1'b0;
                        p_addr      <= ram_rd_data_i[ADDR_MSB:ADDR_LSB];
                        p_mode      <= ram_rd_data_i[MODE_BIT];
                        p_x         <= ram_rd_data_i[X_MSB:X_LSB];
                        state       <= ST_EVAL;
                    end

                    ST_EVAL: begin
                        p_hflip <= ram_rd_data_i[HFLIP_BIT];
                        p_z     <= ram_rd_data_i[Z_MSB:Z_LSB];
                        p_coll  <= ram_rd_data_i[COLL_MSB:COLL_LSB];
                        p_pal   <= ram_rd_data_i[PAL_MSB:PAL_LSB];
                        p_width <= ram_rd_data_i[W_MSB:W_LSB];
                        p_row   <= vis_row;
`ifdef SPRITE_SCAN_OVF_EN
                        if (vis && emit_full) begin
                            ovf_o <= 1'b1;
                        end
`endif
                        if (take) begin
                            state <= ST_PUSH;
                        end else if (last_n) begin
                            done_o <= 1'b1;
                            state  <= ST_FIN;
                        end else begin
                            spr_n         <= spr_n + 7'd1;
                            ram_rd_en_o   <= 1'b1;
                            ram_rd_addr_o <= {spr_n + 7'd1, 1'b0};
                            state         <= ST_RD0;
                        end
                    end

                    ST_PUSH: begin
                        if (can_load) begin
                            spr_valid_o <= 1'b1;
                            spr_idx_o   <= spr_n;
                            spr_addr_o  <= p_addr;
                            spr_mode_o  <= p_mode;
                            spr_x_o     <= p_x;
                            spr_row_o   <= p_row;
                            spr_hflip_o <= p_hflip;
                            spr_z_o     <= p_z;
                            spr_coll_o  <= p_coll;
                            spr_pal_o   <= p_pal;
                            spr_width_o <= p_width;
                            emit_cnt    <= emit_cnt + 8'd1;
                            if (last_n || stop_at_limit) begin
                                done_o <= 1'b1;
                                state  <= ST_FIN;
                            end else begin
                                spr_n         <= spr_n + 7'd1;
                                ram_rd_en_o   <= 1'b1;
                                ram_rd_addr_o <= {spr_n + 7'd1, 1'b0};
                                state         <= ST_RD0;
                            end
                        end
                    end

                    ST_FIN: begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end

                    default: begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_scan_ctrl.sv
module tb_sprite_scan_ctrl;

    localparam int MAXL = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        line_start_i;
    logic [9:0]  line_i;
    logic        ram_rd_en_o;
    logic [7:0]  ram_rd_addr_o;
    logic [31:0] ram_rd_data_i;
    logic        spr_valid_o;
    logic        spr_ready_i;
    logic [6:0]  spr_idx_o;
    logic [11:0] spr_addr_o;
    logic        spr_mode_o;
    logic [9:0]  spr_x_o;
    logic [5:0]  spr_row_o;
    logic        spr_hflip_o;
    logic [1:0]  spr_z_o;
    logic [3:0]  spr_coll_o;
    logic [3:0]  spr_pal_o;
    logic [1:0]  spr_width_o;
    logic        busy_o;
    logic        done_o;
`ifdef SPRITE_SCAN_OVF_EN
    logic        ovf_o;
`endif

    sprite_scan_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .line_start_i  (line_start_i),
        .line_i        (line_i),
        .ram_rd_en_o   (ram_rd_en_o),
        .ram_rd_addr_o (ram_rd_addr_o),
        .ram_rd_data_i (ram_rd_data_i),
        .spr_valid_o   (spr_valid_o),
        .spr_ready_i   (spr_ready_i),
        .spr_idx_o     (spr_idx_o),
        .spr_addr_o    (spr_addr_o),
        .spr_mode_o    (spr_mode_o),
        .spr_x_o       (spr_x_o),
        .spr_row_o     (spr_row_o),
        .spr_hflip_o   (spr_hflip_o),
        .spr_z_o       (spr_z_o),
        .spr_coll_o    (spr_coll_o),
        .spr_pal_o     (spr_pal_o),
        .spr_width_o   (spr_width_o),
`ifdef SPRITE_SCAN_OVF_EN
        .ovf_o         (ovf_o),
`endif
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    // synchronous-read attribute RAM
    logic [31:0] mem [0:255];
    always @(posedge clk_i) begin
        if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
    end

    typedef logic [48:0] desc_t;
    desc_t       exp_q[$];
    logic        ovf_exp;
    desc_t       dut_desc;
    int          checks = 0;
    int          errors = 0;
    int          xfer_cnt, done_cnt, valid_cycles, rd_cycles;
    logic [6:0]  first_idx, last_idx;
    logic [5:0]  last_row;

    assign dut_desc = {spr_idx_o, spr_addr_o, spr_mode_o, spr_x_o, spr_row_o,
                       spr_hflip_o, spr_z_o, spr_coll_o, spr_pal_o, spr_width_o};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected descriptor list for one line, straight from the attribute layout
    task automatic build_model(input logic [9:0] line);
        int cnt;
        cnt = 0;
        exp_q.delete();
        ovf_exp = 1'b0;
        for (int i = 0; i < 128; i++) begin
            logic [31:0] a0, a1;
            logic [9:0]  rel;
            int          h, r;
            logic [6:0]  idx;
            a0  = mem[2*i];
            a1  = mem[2*i+1];
            h   = 8 << a1[31:30];
            rel = line - a1[9:0];
            idx = 7'(i);
            if (a1[19:18] != 2'b00 && int'(rel) < h) begin
                r = a1[17] ? (h - 1 - int'(rel)) : int'(rel);
                if (cnt < MAXL)
                    exp_q.push_back({idx, a0[11:0], a0[15], a0[25:16], r[5:0],
                                     a1[16], a1[19:18], a1[23:20], a1[27:24], a1[29:28]});
                else
                    ovf_exp = 1'b1;
                cnt++;
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic set_sprite(input int i, input logic [9:0] y, input logic [1:0] h,
                              input logic [1:0] z, input logic vflip);
        logic [9:0] x;
        x = 10'(i * 7 + 3);
        mem[2*i]   = {6'h0, x, logic'(i % 2), 3'b0, 12'(12'h100 + i)};
        mem[2*i+1] = {h, 2'd2, y[3:0], 4'h5, z, vflip, 1'b1, 6'h0, y};
    endtask

    task automatic pulse_line(input logic [9:0] l);
        build_model(l);
        xfer_cnt     = 0;
        valid_cycles = 0;
        line_i       = l;
        line_start_i = 1'b1;
        @(posedge clk_i); #1;
        line_start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        while (!done_o && c < budget) begin
            @(posedge clk_i); #1;
            c++;
        end
        check_val(tag, done_o, 1'b1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int c;
        c = 0;
        while (!spr_valid_o && c < budget) begin
            @(posedge clk_i); #1;
            c++;
        end
        check_val(tag, spr_valid_o, 1'b1);
    endtask

    // scoreboard: every transfer pops and compares one expected descriptor
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (done_o) done_cnt++;
            if (spr_valid_o) valid_cycles++;
            if (ram_rd_en_o) rd_cycles++;
            if (spr_valid_o && spr_ready_i) begin
                if (xfer_cnt == 0) first_idx = spr_idx_o;
                last_idx = spr_idx_o;
                last_row = spr_row_o;
                xfer_cnt++;
                check_val("sb_has_entry", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) check_val("sb_desc", dut_desc, exp_q.pop_front());
            end
        end
    end

    initial begin
        int cyc;
        desc_t held;
        int unstable;
        rst_i = 1'b1; line_start_i = 1'b0; line_i = '0; spr_ready_i = 1'b1;
        xfer_cnt = 0; done_cnt = 0; valid_cycles = 0; rd_cycles = 0;
        first_idx = '0; last_idx = '0; last_row = '0;
        clear_mem();
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_valid", spr_valid_o, 1'b0);
        check_val("rst_busy", busy_o, 1'b0);
        check_val("rst_done", done_o, 1'b0);
        check_val("rst_rd_en", ram_rd_en_o, 1'b0);
        check_val("rst_desc", dut_desc, 49'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // single sprite, plain
        clear_mem();
        set_sprite(0, 10'd3, 2'd0, 2'd3, 1'b0);
        done_cnt = 0;
        pulse_line(10'd5);
        check_val("t1_busy", busy_o, 1'b1);
        wait_done("t1_done_to", 600);
        repeat (3) @(posedge clk_i);
        #1;
        check_val("t1_xfers", xfer_cnt, 1);
        check_val("t1_idx", first_idx, 7'd0);
        check_val("t1_row", last_row, 6'd2);
        check_val("t1_done_cnt", done_cnt, 1);
        check_val("t1_idle", busy_o, 1'b0);

        // wrap-around with vflip
        clear_mem();
        set_sprite(5, 10'd1020, 2'd1, 2'd1, 1'b1);
        pulse_line(10'd2);
        wait_done("t2_done_to", 600);
        repeat (3) @(posedge clk_i);
        #1;
        check_val("t2_xfers", xfer_cnt, 1);
        check_val("t2_idx", last_idx, 7'd5);
        check_val("t2_row", last_row, 6'd9);

        // nothing visible: exact scan length
        clear_mem();
        done_cnt = 0;
        pulse_line(10'd7);
        cyc = 1;
        while (!done_o && cyc < 1000) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        check_val("t3_done_cycles", cyc, 3 * 128 + 1);
        repeat (3) @(posedge clk_i);
        #1;
        check_val("t3_valid_cycles", valid_cycles, 0);
        check_val("t3_done_cnt", done_cnt, 1);

        // 100 visible, limit 64
        clear_mem();
        for (int i = 0; i < 100; i++) set_sprite(i, 10'd0, 2'd0, 2'd1, 1'b0);
        done_cnt = 0;
        pulse_line(10'd3);
        wait_done("t4_done_to", 1000);
        repeat (3) @(posedge clk_i);
        #1;
        check_val("t4_xfers", xfer_cnt, 64);
        check_val("t4_last_idx", last_idx, 7'd63);
        check_val("t4_done_cnt", done_cnt, 1);
`ifdef SPRITE_SCAN_OVF_EN
        check_val("t4_ovf", ovf_o, 1'b1);
        check_val("t4_ovf_model", ovf_o, ovf_exp);
`endif

        // back-pressure
        clear_mem();
        set_sprite(10, 10'd48, 2'd0, 2'd1, 1'b0);
        set_sprite(11, 10'd45, 2'd1, 2'd2, 1'b1);
        spr_ready_i = 1'b0;
        pulse_line(10'd50);
`ifdef SPRITE_SCAN_OVF_EN
        check_val("t5_ovf_clr", ovf_o, 1'b0);
`endif
        wait_valid("t5_valid_to", 200);
        repeat (6) @(posedge clk_i);
        #1;
        check_val("t5_stall_idx", spr_idx_o, 7'd10);
        held = dut_desc;
        unstable = 0;
        rd_cycles = 0;
        repeat (20) begin
            @(posedge clk_i); #1;
            if (!spr_valid_o || dut_desc !== held) unstable++;
        end
        check_val("t5_stable", unstable, 0);
        check_val("t5_no_reads", rd_cycles, 0);
        spr_ready_i = 1'b1;
        wait_done("t5_done_to", 600);
        repeat (3) @(posedge clk_i);
        #1;
        check_val("t5_xfers", xfer_cnt, 2);
        check_val("t5_last_idx", last_idx, 7'd11);
        check_val("t5_last_row", last_row, 6'd10);

        // abort mid-scan with a pending descriptor
        clear_mem();
        set_sprite(0, 10'd100, 2'd3, 2'd2, 1'b0);
        for (int i = 1; i < 10; i++) set_sprite(i, 10'd96, 2'd0, 2'd2, 1'b0);
        set_sprite(30, 10'd138, 2'd0, 2'd1, 1'b0);
        spr_ready_i = 1'b0;
        done_cnt = 0;
        pulse_line(10'd100);
        repeat (49) @(posedge clk_i);
        #1;
        check_val("t6_pending", spr_valid_o, 1'b1);
        pulse_line(10'd140);
        check_val("t6_dropped", spr_valid_o, 1'b0);
        check_val("t6_busy", busy_o, 1'b1);
        spr_ready_i = 1'b1;
        wait_done("t6_done_to", 600);
        repeat (3) @(posedge clk_i);
        #1;
        check_val("t6_done_cnt", done_cnt, 1);
        check_val("t6_xfers", xfer_cnt, 2);
        check_val("t6_first_idx", first_idx, 7'd0);
        check_val("t6_last_idx", last_idx, 7'd30);
        check_val("t6_q_empty", exp_q.size(), 0);

        // reset mid-scan
        spr_ready_i = 1'b0;
        pulse_line(10'd100);
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_val("t7_valid", spr_valid_o, 1'b0);
        check_val("t7_busy", busy_o, 1'b0);
        check_val("t7_rd_en", ram_rd_en_o, 1'b0);
        check_val("t7_addr", ram_rd_addr_o, 8'h0);
        check_val("t7_desc", dut_desc, 49'h0);
`ifdef SPRITE_SCAN_OVF_EN
        check_val("t7_ovf", ovf_o, 1'b0);
`endif
        rst_i = 1'b0;
        exp_q.delete();
        spr_ready_i = 1'b1;
        @(posedge clk_i); #1;

        // recovery after reset
        pulse_line(10'd140);
        wait_done("t8_done_to", 600);
        repeat (3) @(posedge clk_i);
        #1;
        check_val("t8_xfers", xfer_cnt, 2);
        check_val("t8_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_scan_ctrl.md
Name: sprite_scan_ctrl

Overview:
- Per-scanline sprite attribute scanner.
- Sequences the read port of the 256x32 sprite attribute RAM. Sprite n occupies word 2n (attr0) and word 2n+1 (attr1).
- On each line start, walks sprites 0..127 and tests each for vertical intersection with the current line.
- Pushes visible sprites, in index order, to the sprite line renderer over a valid/ready interface.

Parameters:
- NUM_SPRITES, 128, number of sprites scanned per line (1..128).
- MAX_PER_LINE, 64, maximum sprites emitted per line (1..128); scanning stops once reached.

Ports:
- clk_i  in  1  system clock; also drives the RAM read clock.
- rst_i  in  1  synchronous, active-high reset.
- line_start_i  in  1  one-cycle pulse that starts a scan.
- line_i  in  10  line number, sampled when line_start_i is high.
- ram_rd_en_o  out  1  RAM read enable.
- ram_rd_addr_o  out  8  RAM read address.
- ram_rd_data_i  in  32  RAM read data; valid 1 cycle after the address.
- spr_valid_o  out  1  output sprite descriptor valid.
- spr_ready_i  in  1  renderer accepts the descriptor.
- spr_idx_o  out  7  sprite index.
- spr_addr_o  out  12  pixel data address (attr0[11:0]).
- spr_mode_o  out  1  1 = 8bpp (attr0[15]).
- spr_x_o  out  10  x position (attr0[25:16]).
- spr_row_o  out  6  row within sprite, vflip applied.
- spr_hflip_o  out  1  attr1[16].
- spr_z_o  out  2  attr1[19:18].
- spr_coll_o  out  4  attr1[23:20].
- spr_pal_o  out  4  attr1[27:24].
- spr_width_o  out  2  attr1[29:28].
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset: all outputs 0; state IDLE; sprite counter 0; emit counter 0.
- States and transitions:
  - IDLE: on line_start_i, latch line_i, clear counters, go to RD0.
  - RD0: ram_rd_en_o=1, ram_rd_addr_o={n,0}; go to RD1.
  - RD1: ram_rd_en_o=1, ram_rd_addr_o={n,1}; latch ram_rd_data_i as attr0; go to EVAL.
  - EVAL: latch attr1; compute visibility.
    - Visible: go to PUSH.
    - Not visible: advance n, then go to RD0, or to FIN if n was last.
  - PUSH: load the output register when !spr_valid_o or spr_ready_i; increment emit count; advance n. Next state is RD0, or FIN if n was last or the emit count reached MAX_PER_LINE. Otherwise hold in PUSH.
  - FIN: done_o=1 for one cycle; go to IDLE. Any descriptor still valid stays valid until accepted.
- Visibility rule:
  - height_px = 8<<attr1[31:30] (8..64).
  - rel = (line - attr1[9:0]) mod 1024, 10-bit wrap.
  - visible iff attr1[19:18]!=0 and rel < height_px.
- spr_row_o = vflip (attr1[17]) ? height_px-1-rel : rel, truncated to 6 bits.
- Minimum throughput: 3 cycles per invisible sprite, 4 per visible sprite with no stall. Full 128-sprite scan: at most 512 cycles plus back-pressure.
- Output handshake:
  - Transfer occurs when spr_valid_o && spr_ready_i.
  - spr_valid_o stays high and the descriptor fields stay stable until the transfer.
  - On a transfer with no new load, spr_valid_o drops the next cycle.
- busy_o is high in every state except IDLE.
- line_start_i while busy: abort the scan. Clear spr_valid_o (the pending descriptor is dropped), relatch line_i, restart at n=0 in RD0. No done_o for the aborted scan.
- Reset mid-scan: immediate return to IDLE; all outputs 0 the next cycle.
- Write-port activity during a scan is not blocked. Writes to a sprite already read take effect on the next line.

Optional Feature:
- Macro: SPRITE_SCAN_OVF_EN.
- When defined, adds output port ovf_o (1 bit).
  - Set if a visible sprite is found after MAX_PER_LINE have been emitted. In this mode the scan continues evaluating the remaining sprites, without emitting them, so the overflow can be detected.
  - Cleared on the next line_start_i.
- When undefined: no port; the scan stops at the limit.

Decomposition:
- Shared package sprite_pkg:
  - attribute field bit positions (ADDR, MODE, X, Y, HFLIP, VFLIP, Z, COLL, PAL, W, H);
  - scan state enum;
  - constant NUM_SPRITE_SLOTS=128.
- One natural sub-module: sprite_vis_calc. Combinational: line, attr1 -> visible, row.

Test Plan:
- Sprite 0: y=3, h=0 (8px), z=3, vflip=0; line=5 -> one descriptor, idx=0, row=2; done_o after the 128-sprite scan.
- Sprite 5: y=1020, h=1 (16px), vflip=1; line=2 -> visible via wrap, rel=6, row=9.
- z=0 on all sprites -> no spr_valid_o; done_o pulses exactly 512-... no: exactly 3*128+1 cycles after the line_start_i pulse.
- 100 sprites visible with MAX_PER_LINE=64 -> exactly 64 descriptors, idx 0..63. With SPRITE_SCAN_OVF_EN, ovf_o=1.
- Hold spr_ready_i=0 for 20 cycles with 2 visible sprites -> first descriptor stable; no RAM reads during the stall; both delivered in order.
- line_start_i at cycle 50 of a scan -> pending valid dropped; rescan from idx 0 with the new line; a single done_o.
